// File: rtl/nes_bus_arbiter.sv
// nes_bus_arbiter: N-master CPU bus arbiter with fixed or round-robin priority, grant locking,
// registered read return and a saturating contention counter.
module nes_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int RR_MODE     = 0,
    parameter int CNT_W       = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [NUM_MASTERS-1:0]        req_in,
    input  logic [NUM_MASTERS-1:0]        lock_in,
    input  logic [NUM_MASTERS*ADDR_W-1:0] a_in,
    input  logic [NUM_MASTERS-1:0]        r_nw_in,
    input  logic [NUM_MASTERS*DATA_W-1:0] d_in,
    input  logic [DATA_W-1:0]             bus_d_in,
    output logic [NUM_MASTERS-1:0]        gnt_out,
    output logic [NUM_MASTERS-1:0]        rdy_out,
    output logic [ADDR_W-1:0]             bus_a_out,
    output logic                          bus_r_nw_out,
    output logic [DATA_W-1:0]             bus_d_out,
    output logic [DATA_W-1:0]             rd_d_out,
    output logic [NUM_MASTERS-1:0]        rd_vld_out,
    output logic [CNT_W-1:0]              conflict_cnt_out
);
    localparam int IW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] gnt_d, live;
    logic [IW-1:0]          last_q, last_d, idx;
    logic                   hold, rd_fire;
    int                     n_req;

    always_comb begin
        hold   = |(gnt_out & req_in & lock_in);
        gnt_d  = '0;
        last_d = last_q;
        idx    = '0;
        if (hold) begin
            gnt_d = gnt_out;
        end else if (RR_MODE != 0) begin
            // descending scan so the nearest requester after last_owner is the one kept
            for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
                idx = IW'((int'(last_q) + 1 + k) % NUM_MASTERS);
                if (req_in[idx]) begin
                    gnt_d      = '0;
                    gnt_d[idx] = 1'b1;
                    last_d     = idx;
                end
            end
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (req_in[i]) begin
                    gnt_d    = '0;
                    gnt_d[i] = 1'b1;
                    last_d   = IW'(i);
                end
            end
        end
    end

    // bus only driven by a live grant; reset also blanks it so no write leaks out mid-reset
    always_comb begin
        live         = gnt_out & req_in & {NUM_MASTERS{~rst_in}};
        bus_a_out    = '0;
        bus_r_nw_out = 1'b1;
        bus_d_out    = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (live[i]) begin
                bus_a_out    = a_in[i*ADDR_W +: ADDR_W];
                bus_r_nw_out = r_nw_in[i];
                bus_d_out    = d_in[i*DATA_W +: DATA_W];
            end
        end
        rd_fire = |live & bus_r_nw_out;
        n_req   = 0;
        for (int i = 0; i < NUM_MASTERS; i++) n_req += int'(req_in[i]);
    end

    assign rdy_out = gnt_out;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            gnt_out          <= '0;
            last_q           <= '0;
            rd_vld_out       <= '0;
            rd_d_out         <= '0;
            conflict_cnt_out <= '0;
        end else begin
            gnt_out    <= gnt_d;
            last_q     <= last_d;
            rd_vld_out <= rd_fire ? live : '0;
            if (rd_fire) rd_d_out <= bus_d_in;
            if (n_req >= 2 && !(&conflict_cnt_out)) conflict_cnt_out <= conflict_cnt_out + 1'b1;
        end
    end
endmodule

// File: tb/tb_nes_bus_arbiter.sv
// tb_nes_bus_arbiter: fixed-priority (2 masters, 4-bit counter) and round-robin (3 masters)
// arbiters driven by shared stimulus and checked against a per-cycle transaction model.
module tb_nes_bus_arbiter;
    logic        clk = 0;
    logic        rst;
    logic [2:0]  req, lock, rnw;
    logic [47:0] a;
    logic [23:0] d;
    logic [7:0]  bus_d;

    logic [1:0]  f_gnt, f_rdy, f_vld;
    logic [15:0] f_bus_a;
    logic        f_bus_rnw;
    logic [7:0]  f_bus_d, f_rd_d;
    logic [3:0]  f_cnt;
    logic [2:0]  r_gnt, r_rdy, r_vld;
    logic [15:0] r_bus_a;
    logic        r_bus_rnw;
    logic [7:0]  r_bus_d, r_rd_d;
    logic [15:0] r_cnt;

    int errors = 0, checks = 0;
    int own[2], last[2], vld[2], cnt[2];
    logic [7:0] rdd[2];

    always #5 clk = ~clk;

    nes_bus_arbiter #(.NUM_MASTERS(2), .RR_MODE(0), .CNT_W(4)) u_fix (
        .clk_in(clk), .rst_in(rst), .req_in(req[1:0]), .lock_in(lock[1:0]), .a_in(a[31:0]),
        .r_nw_in(rnw[1:0]), .d_in(d[15:0]), .bus_d_in(bus_d), .gnt_out(f_gnt), .rdy_out(f_rdy),
        .bus_a_out(f_bus_a), .bus_r_nw_out(f_bus_rnw), .bus_d_out(f_bus_d), .rd_d_out(f_rd_d),
        .rd_vld_out(f_vld), .conflict_cnt_out(f_cnt));

    nes_bus_arbiter #(.NUM_MASTERS(3), .RR_MODE(1), .CNT_W(16)) u_rr (
        .clk_in(clk), .rst_in(rst), .req_in(req), .lock_in(lock), .a_in(a),
        .r_nw_in(rnw), .d_in(d), .bus_d_in(bus_d), .gnt_out(r_gnt), .rdy_out(r_rdy),
        .bus_a_out(r_bus_a), .bus_r_nw_out(r_bus_rnw), .bus_d_out(r_bus_d), .rd_d_out(r_rd_d),
        .rd_vld_out(r_vld), .conflict_cnt_out(r_cnt));

    function automatic int nm(int k);
        return k == 0 ? 2 : 3;
    endfunction

    function automatic bit is_live(int k);
        return own[k] >= 0 && req[own[k]] && !rst;
    endfunction

    // next owner from the arbitration rules: lock hold, else highest index or next-after-last
    function automatic int arb(int k);
        int n = nm(k);
        if (own[k] >= 0 && req[own[k]] && lock[own[k]]) return own[k];
        if (k == 0) begin
            for (int i = n - 1; i >= 0; i--) if (req[i]) return i;
        end else begin
            for (int s = 1; s <= n; s++) if (req[(last[k] + s) % n]) return (last[k] + s) % n;
        end
        return -1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] oh(int i);
        return i >= 0 ? 32'(1) << i : 32'(0);
    endfunction

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] ea, ed, er;
            bit lv = is_live(k);
            ea = lv ? 32'(a[own[k]*16 +: 16]) : 0;
            ed = lv ? 32'(d[own[k]*8 +: 8]) : 0;
            er = lv ? 32'(rnw[own[k]]) : 1;
            if (k == 0) begin
                chk("f_gnt", 32'(f_gnt), oh(own[0]));
                chk("f_rdy", 32'(f_rdy), oh(own[0]));
                chk("f_bus_a", 32'(f_bus_a), ea);
                chk("f_bus_rnw", 32'(f_bus_rnw), er);
                chk("f_bus_d", 32'(f_bus_d), ed);
                chk("f_rd_d", 32'(f_rd_d), 32'(rdd[0]));
                chk("f_rd_vld", 32'(f_vld), oh(vld[0]));
                chk("f_cnt", 32'(f_cnt), 32'(cnt[0]));
            end else begin
                chk("r_gnt", 32'(r_gnt), oh(own[1]));
                chk("r_rdy", 32'(r_rdy), oh(own[1]));
                chk("r_bus_a", 32'(r_bus_a), ea);
                chk("r_bus_rnw", 32'(r_bus_rnw), er);
                chk("r_bus_d", 32'(r_bus_d), ed);
                chk("r_rd_d", 32'(r_rd_d), 32'(rdd[1]));
                chk("r_rd_vld", 32'(r_vld), oh(vld[1]));
                chk("r_cnt", 32'(r_cnt), 32'(cnt[1]));
            end
        end
    endtask

    // one bus cycle: check mid-cycle, then advance the model with the values sampled at the edge
    task automatic step();
        #4;
        check_model();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            int pop = 0;
            for (int i = 0; i < nm(k); i++) pop += int'(req[i]);
            if (rst) begin
                own[k] = -1; last[k] = 0; vld[k] = -1; rdd[k] = 0; cnt[k] = 0;
            end else begin
                int nx;
                if (is_live(k) && rnw[own[k]]) begin
                    vld[k] = own[k];
                    rdd[k] = bus_d;
                end else vld[k] = -1;
                if (pop >= 2 && cnt[k] < (k == 0 ? 15 : 65535)) cnt[k]++;
                nx = arb(k);
                own[k] = nx;
                if (nx >= 0) last[k] = nx;
            end
        end
        #1;
    endtask

    typedef struct {
        logic [2:0] req, lock;
        logic [2:0] gnt_r;
        logic [1:0] gnt_f;
    } vec_t;
    vec_t tbl[9];

    initial begin
        tbl[0] = '{3'b111, 3'b010, 3'b000, 2'b00};
        for (int i = 1; i <= 4; i++) tbl[i] = '{3'b111, 3'b010, 3'b010, 2'b10};
        tbl[5] = '{3'b111, 3'b000, 3'b010, 2'b10};
        tbl[6] = '{3'b111, 3'b000, 3'b100, 2'b10};
        tbl[7] = '{3'b000, 3'b000, 3'b001, 2'b10};
        tbl[8] = '{3'b000, 3'b000, 3'b000, 2'b00};

        rst = 1; req = 0; lock = 0; rnw = 3'b111; a = 0; d = 0; bus_d = 0;
        for (int k = 0; k < 2; k++) begin own[k] = -1; last[k] = 0; vld[k] = -1; rdd[k] = 0; cnt[k] = 0; end
        @(posedge clk); #1;
        step();
        rst = 0;

        // lock hold then round-robin rotation, fixed instance stays on its top master
        a = {$urandom, $urandom};
        for (int i = 0; i < 9; i++) begin
            req = tbl[i].req; lock = tbl[i].lock;
            chk("tbl_gnt_r", 32'(r_gnt), 32'(tbl[i].gnt_r));
            chk("tbl_gnt_f", 32'(f_gnt), 32'(tbl[i].gnt_f));
            step();
        end

        // fixed preemption of a reading master 0 by master 1
        a = 0; a[15:0] = 16'h8000; a[31:16] = 16'h2002; rnw = 3'b111; req = 3'b001; lock = 0;
        for (int i = 0; i < 10; i++) step();
        req = 3'b011;
        step();
        chk("pre_gnt", 32'(f_gnt), 32'h2);
        chk("pre_vld", 32'(f_vld), 32'h1);
        chk("pre_bus_a", 32'(f_bus_a), 32'h2002);

        // read return, then a write produces no valid
        req = 3'b001; a[15:0] = 0; bus_d = 8'h5A; step(); step(); step();
        chk("rd_d", 32'(f_rd_d), 32'h5A);
        chk("rd_vld", 32'(f_vld), 32'h1);
        rnw = 3'b000; step();
        chk("wr_no_vld", 32'(f_vld), 32'h0);

        // idle safety: granted writer drops its request
        req = 3'b000; #1;
        chk("idle_rnw", 32'(f_bus_rnw), 32'h1);
        step();
        chk("idle_gnt", 32'(f_gnt), 32'h0);

        // reset during a locked write
        req = 3'b001; lock = 3'b001; rnw = 3'b110; a[15:0] = 16'h1234; d[7:0] = 8'hC3;
        step(); step();
        rst = 1; #1;
        chk("rst_cyc_rnw", 32'(f_bus_rnw), 32'h1);
        step();
        rst = 0; #1;
        chk("rst_gnt", 32'(f_gnt), 32'h0);
        chk("rst_bus_a", 32'(f_bus_a), 32'h0);
        chk("rst_bus_rnw", 32'(f_bus_rnw), 32'h1);
        chk("rst_cnt", 32'(f_cnt), 32'h0);

        // counter saturation on the 4-bit instance
        req = 3'b011; lock = 0;
        for (int i = 0; i < 20; i++) step();
        chk("sat_cnt", 32'(f_cnt), 32'hF);
        step();
        chk("sat_hold", 32'(f_cnt), 32'hF);

        for (int i = 0; i < 400; i++) begin
            req = 3'($urandom); lock = 3'($urandom); rnw = 3'($urandom);
            a = {$urandom, $urandom}; d = 24'($urandom); bus_d = 8'($urandom);
            rst = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
